// File: rtl/cache_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the cache port arbiter.
//   BUS_W / BE_W : cache data/address width and byte-enable width
//   MAX_REQ      : largest supported requester count (rr_pick operates on this width)
//   arb_state_t  : lock state of the arbiter
//   rr_pick      : first set request at or after ptr, wrapping modulo n
package cache_arb_pkg;

  localparam int unsigned BUS_W     = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned REQ_IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_GNT = 1'b1
  } arb_state_t;

  // Returns ptr when no request is set; callers gate the result with "any request".
  function automatic logic [REQ_IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [REQ_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [REQ_IDX_W-1:0] pick;
    logic                 found;
    logic [31:0]          idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!found && (i < n) && req[idx[REQ_IDX_W-1:0]]) begin
        pick  = idx[REQ_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signals of the cache port arbiter.
//   master : environment view (requesters and cache drive their inputs, observe arbiter outputs)
//   slave  : arbiter view
// Requester k occupies bits [32k+31:32k] of addr_i/wdata_i and [4k+3:4k] of be_i.
interface cache_port_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*BUS_W-1:0] addr_i;
  logic [NUM_REQ*BUS_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]       we_i;
  logic [NUM_REQ*BE_W-1:0]  be_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       rvalid_o;
  logic [BUS_W-1:0]         rdata_o;

  logic                     cache_req_o;
  logic [BUS_W-1:0]         cache_addr_o;
  logic [BUS_W-1:0]         cache_wdata_o;
  logic                     cache_we_o;
  logic [BE_W-1:0]          cache_be_o;
  logic                     cache_gnt_i;
  logic                     cache_rvalid_i;
  logic [BUS_W-1:0]         cache_rdata_i;

  logic                     busy_o;
  logic                     proto_err_o;

  modport master (
    output req_i, addr_i, wdata_i, we_i, be_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  cache_req_o, cache_addr_o, cache_wdata_o, cache_we_o, cache_be_o,
    output cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    input  busy_o, proto_err_o
  );

  modport slave (
    input  req_i, addr_i, wdata_i, we_i, be_i,
    output gnt_o, rvalid_o, rdata_o,
    output cache_req_o, cache_addr_o, cache_wdata_o, cache_we_o, cache_be_o,
    input  cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    output busy_o, proto_err_o
  );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted requester indices awaiting their response.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write din when not full
//   pop, dout  : dout is the head entry; pop removes it when not empty
//   full/empty : occupancy flags
module arb_id_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; empty gates every use of dout.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache port among NUM_REQ requesters, with
// in-order response steering and zero added latency on either path.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester request/payload/grant/response and cache port (slave view)
//   busy_o     : at least one granted transaction still awaits its response
//   proto_err_o: sticky; set by a cache response arriving with nothing outstanding
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IDW             = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_port_arbiter_if.slave   bus
);

  arb_state_t         state;
  logic [IDW-1:0]     locked_idx;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     head_idx;
  logic [MAX_REQ-1:0] req_vec;
  logic               lock;
  logic               fifo_full;
  logic               fifo_empty;
  logic               cache_req;
  logic               gnt_c;
  logic               rsp_ok;
  logic               proto_err;

  logic [BUS_W-1:0]   mux_addr;
  logic [BUS_W-1:0]   mux_wdata;
  logic               mux_we;
  logic [BE_W-1:0]    mux_be;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [NUM_REQ-1:0] rvalid_vec;

  assign lock    = (state == ARB_WAIT_GNT);
  assign req_vec = MAX_REQ'(bus.req_i);

  // A waiting request keeps its slot until the cache accepts it.
  assign sel = lock ? locked_idx
                    : IDW'(rr_pick(req_vec, REQ_IDX_W'(rr_ptr), NUM_REQ));

  assign cache_req = ((|bus.req_i) | lock) & ~fifo_full;
  assign gnt_c     = cache_req & bus.cache_gnt_i;
  // A same-cycle response always belongs to the FIFO head, never to this cycle's grant.
  assign rsp_ok    = bus.cache_rvalid_i & ~fifo_empty;

  // Payload mux toward the cache, grant decode and response demux.
  always_comb begin
    mux_addr   = '0;
    mux_wdata  = '0;
    mux_we     = 1'b0;
    mux_be     = '0;
    gnt_vec    = '0;
    rvalid_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IDW'(k)) begin
        mux_addr   = bus.addr_i[k*BUS_W +: BUS_W];
        mux_wdata  = bus.wdata_i[k*BUS_W +: BUS_W];
        mux_we     = bus.we_i[k];
        mux_be     = bus.be_i[k*BE_W +: BE_W];
        gnt_vec[k] = gnt_c;
      end
      if (head_idx == IDW'(k)) begin
        rvalid_vec[k] = rsp_ok;
      end
    end
  end

  assign bus.cache_req_o   = cache_req;
  assign bus.cache_addr_o  = mux_addr;
  assign bus.cache_wdata_o = mux_wdata;
  assign bus.cache_we_o    = mux_we;
  assign bus.cache_be_o    = mux_be;
  assign bus.gnt_o         = gnt_vec;
  assign bus.rvalid_o      = rvalid_vec;
  assign bus.rdata_o       = bus.cache_rdata_i;
  assign bus.busy_o        = ~fifo_empty;
  assign bus.proto_err_o   = proto_err;

  // Lock FSM, round-robin pointer and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      locked_idx <= '0;
      rr_ptr     <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (cache_req && !bus.cache_gnt_i) begin
            state      <= ARB_WAIT_GNT;
            locked_idx <= sel;
          end
        end
        ARB_WAIT_GNT: begin
          if (gnt_c) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
      if (gnt_c) begin
        rr_ptr <= (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);
      end
      if (bus.cache_rvalid_i && fifo_empty) begin
        proto_err <= 1'b1;
      end
    end
  end

  arb_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_c),
    .pop   (rsp_ok),
    .din   (sel),
    .dout  (head_idx),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
